// File: rtl/top_module_hls_deadlock_report.sv
// Debounces the dataflow deadlock monitor's block flag, latches a sticky deadlock report,
// freezes the stall vectors at detection and tracks stall duration and event count.
module top_module_hls_deadlock_report #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 block_in,
  input  logic [1:0]           axis_block_sigs,
  input  logic [12:0]          inst_idle_sigs,
  input  logic [8:0]           inst_block_sigs,
  input  logic                 clear,
  output logic                 deadlock_detected,
  output logic                 deadlock_pulse,
  output logic [1:0]           snap_axis_block,
  output logic [12:0]          snap_idle,
  output logic [8:0]           snap_block,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [DBC_W-1:0] dbc_r;
  logic [DBC_W-1:0] dbc_s;
  logic             detect_s;

  // State and debounce counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      dbc_r   <= {DBC_W{1'b0}};
    end else begin
      state_r <= state_s;
      dbc_r   <= dbc_s;
    end
  end

  // Next-state and debounce logic; clear wins over a same-cycle detection
  always_comb begin
    state_s  = state_r;
    dbc_s    = dbc_r;
    detect_s = 1'b0;
    if (clear) begin
      state_s = IDLE;
      dbc_s   = {DBC_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (block_in) begin
            dbc_s = DBC_W'(1);
            if (DEBOUNCE_CYCLES == 1) begin
              state_s  = LOCKED;
              detect_s = 1'b1;
            end else begin
              state_s = ARMING;
            end
          end else begin
            dbc_s = {DBC_W{1'b0}};
          end
        end
        ARMING: begin
          if (!block_in) begin
            state_s = IDLE;
            dbc_s   = {DBC_W{1'b0}};
          end else if (dbc_r == DBC_LAST) begin
            state_s  = LOCKED;
            detect_s = 1'b1;
          end else begin
            dbc_s = dbc_r + DBC_W'(1);
          end
        end
        LOCKED: begin
          state_s = LOCKED;
        end
        default: begin
          state_s = IDLE;
          dbc_s   = {DBC_W{1'b0}};
        end
      endcase
    end
  end

  // Report outputs: sticky flag, snapshots and saturating counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deadlock_detected <= 1'b0;
      deadlock_pulse    <= 1'b0;
      snap_axis_block   <= 2'b00;
      snap_idle         <= 13'h0000;
      snap_block        <= 9'h000;
      stall_cycles      <= {CNT_WIDTH{1'b0}};
      event_count       <= {CNT_WIDTH{1'b0}};
    end else begin
      deadlock_pulse <= detect_s;
      if (clear) begin
        deadlock_detected <= 1'b0;
        snap_axis_block   <= 2'b00;
        snap_idle         <= 13'h0000;
        snap_block        <= 9'h000;
        stall_cycles      <= {CNT_WIDTH{1'b0}};
      end else if (detect_s) begin
        deadlock_detected <= 1'b1;
        snap_axis_block   <= axis_block_sigs;
        snap_idle         <= inst_idle_sigs;
        snap_block        <= inst_block_sigs;
        stall_cycles      <= {CNT_WIDTH{1'b0}};
        if (event_count != CNT_MAX) begin
          event_count <= event_count + CNT_WIDTH'(1);
        end
      end else if ((state_r == LOCKED) && block_in && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_top_module_hls_deadlock_report.sv
// Directed bench: a vector table for the DEBOUNCE_CYCLES=16 instance plus hand sequences
// for snapshots, async reset, DEBOUNCE_CYCLES=1 and CNT_WIDTH=4 saturation.
module tb_top_module_hls_deadlock_report;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        block_in = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  axis_block_sigs = 2'b11;
  logic [12:0] inst_idle_sigs = 13'h1ABC;
  logic [8:0]  inst_block_sigs = 9'h155;

  logic        det_a, pls_a, det_b, pls_b, det_c, pls_c;
  logic [1:0]  sax_a, sax_b, sax_c;
  logic [12:0] sid_a, sid_b, sid_c;
  logic [8:0]  sbl_a, sbl_b, sbl_c;
  logic [15:0] stl_a, evt_a, stl_b, evt_b;
  logic [3:0]  stl_c, evt_c;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  top_module_hls_deadlock_report #(.DEBOUNCE_CYCLES(16), .CNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .block_in(block_in), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .deadlock_detected(det_a), .deadlock_pulse(pls_a), .snap_axis_block(sax_a),
    .snap_idle(sid_a), .snap_block(sbl_a), .stall_cycles(stl_a), .event_count(evt_a));

  top_module_hls_deadlock_report #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)) u_d1 (
    .clock(clock), .reset(reset), .block_in(block_in), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .deadlock_detected(det_b), .deadlock_pulse(pls_b), .snap_axis_block(sax_b),
    .snap_idle(sid_b), .snap_block(sbl_b), .stall_cycles(stl_b), .event_count(evt_b));

  top_module_hls_deadlock_report #(.DEBOUNCE_CYCLES(2), .CNT_WIDTH(4)) u_c4 (
    .clock(clock), .reset(reset), .block_in(block_in), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .deadlock_detected(det_c), .deadlock_pulse(pls_c), .snap_axis_block(sax_c),
    .snap_idle(sid_c), .snap_block(sbl_c), .stall_cycles(stl_c), .event_count(evt_c));

  typedef struct {
    logic blk;
    logic clr;
    int   n;
    logic det;
    logic pls;
    int   stall;
    int   evt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    block_in = 1'b0;
    clear    = 1'b0;
    reset    = 1'b1;
    step(1);
    reset    = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 15, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 15, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 0, 1};
    tbl[4]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 39, 1'b1, 1'b0, 40, 1};
    tbl[6]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0, 40, 1};
    tbl[7]  = '{1'b1, 1'b0, 20, 1'b1, 1'b0, 60, 1};
    tbl[8]  = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 0, 1};
    tbl[9]  = '{1'b1, 1'b0, 15, 1'b0, 1'b0, 0, 1};
    tbl[10] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 15, 1'b0, 1'b0, 0, 1};
    tbl[12] = '{1'b1, 1'b0, 1,  1'b1, 1'b1, 0, 2};
    tbl[13] = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 0, 2};

    step(2);
    reset = 1'b0;
    chk("rst_det", det_a, 1'b0);
    chk("rst_pulse", pls_a, 1'b0);
    chk("rst_stall", stl_a, 16'd0);
    chk("rst_event", evt_a, 16'd0);
    chk("rst_snap_idle", sid_a, 13'h0000);

    for (int i = 0; i < 14; i++) begin
      block_in = tbl[i].blk;
      clear    = tbl[i].clr;
      step(tbl[i].n);
      clear    = 1'b0;
      chk($sformatf("row%0d_det", i), det_a, tbl[i].det);
      chk($sformatf("row%0d_pulse", i), pls_a, tbl[i].pls);
      chk($sformatf("row%0d_stall", i), stl_a, 16'(tbl[i].stall));
      chk($sformatf("row%0d_event", i), evt_a, 16'(tbl[i].evt));
    end

    // Snapshot captures the vectors of the 16th high sample only
    do_reset();
    for (int k = 0; k < 16; k++) begin
      block_in = 1'b1;
      if (k == 15) begin
        inst_idle_sigs  = 13'h00F0;
        inst_block_sigs = 9'h00F;
        axis_block_sigs = 2'b01;
      end else begin
        inst_idle_sigs  = 13'h1FFF;
        inst_block_sigs = 9'h1FF;
        axis_block_sigs = 2'b10;
      end
      step(1);
    end
    chk("snap_det", det_a, 1'b1);
    chk("snap_pulse", pls_a, 1'b1);
    chk("snap_idle", sid_a, 13'h00F0);
    chk("snap_block", sbl_a, 9'h00F);
    chk("snap_axis", sax_a, 2'b01);
    chk("snap_event", evt_a, 16'd1);
    inst_idle_sigs  = 13'h0AAA;
    inst_block_sigs = 9'h0AA;
    axis_block_sigs = 2'b11;
    step(1);
    chk("snap_pulse_off", pls_a, 1'b0);
    chk("snap_idle_held", sid_a, 13'h00F0);
    chk("snap_stall1", stl_a, 16'd1);

    // Async reset between edges while locked
    #2 reset = 1'b1;
    #2;
    chk("areset_det", det_a, 1'b0);
    chk("areset_event", evt_a, 16'd0);
    chk("areset_stall", stl_a, 16'd0);
    chk("areset_snap_idle", sid_a, 13'h0000);
    chk("areset_snap_axis", sax_a, 2'b00);
    #1 reset = 1'b0;
    step(15);
    chk("rearm_15_det", det_a, 1'b0);
    step(1);
    chk("rearm_16_det", det_a, 1'b1);
    chk("rearm_16_pulse", pls_a, 1'b1);

    // DEBOUNCE_CYCLES=1: a single high sample detects
    do_reset();
    block_in = 1'b1;
    step(1);
    block_in = 1'b0;
    chk("d1_det", det_b, 1'b1);
    chk("d1_pulse", pls_b, 1'b1);
    chk("d1_event", evt_b, 16'd1);
    chk("d16_no_det", det_a, 1'b0);
    step(1);
    chk("d1_pulse_off", pls_b, 1'b0);
    chk("d1_sticky", det_b, 1'b1);

    // CNT_WIDTH=4 saturation of event and stall counters
    do_reset();
    for (int i = 0; i < 17; i++) begin
      block_in = 1'b1;
      step(2);
      block_in = 1'b0;
      clear    = 1'b1;
      step(1);
      clear    = 1'b0;
    end
    chk("c4_event_sat", evt_c, 4'd15);
    chk("c4_cleared", det_c, 1'b0);
    block_in = 1'b1;
    step(2);
    chk("c4_det", det_c, 1'b1);
    step(20);
    chk("c4_stall_sat", stl_c, 4'd15);
    chk("c4_event_hold", evt_c, 4'd15);
    block_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_module_hls_deadlock_report.md
# top_module_hls_deadlock_report

Downstream consumer of the per-instance dataflow deadlock monitor's `block` output. It debounces the monitor's `block` flag over a programmable number of consecutive cycles and latches a sticky deadlock indication. At detection it freezes a snapshot of the stall vectors, then counts stall duration and cumulative deadlock events for the debug/status path. It sits between the deadlock monitor and the top-level status register / simulation reporting logic.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive high `block_in` samples required to declare deadlock; legal range 1..65535.
- `CNT_WIDTH`, 16: width of `stall_cycles` and `event_count`.
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `block_in` in 1: `block` output of the deadlock monitor.
- `axis_block_sigs` in 2: same vector fed to the monitor; snapshot source.
- `inst_idle_sigs` in 13: same vector fed to the monitor; snapshot source.
- `inst_block_sigs` in 9: same vector fed to the monitor; snapshot source.
- `clear` in 1: synchronous, single-cycle request to re-arm after a deadlock report.
- `deadlock_detected` out 1: sticky deadlock flag.
- `deadlock_pulse` out 1: one-cycle strobe at detection.
- `snap_axis_block` out 2: captured `axis_block_sigs` at detection.
- `snap_idle` out 13: captured `inst_idle_sigs` at detection.
- `snap_block` out 9: captured `inst_block_sigs` at detection.
- `stall_cycles` out CNT_WIDTH: cycles `block_in` stayed high after detection; saturating.
- `event_count` out CNT_WIDTH: number of detections since reset; saturating.

## Operation
- Three-state FSM: IDLE, ARMING, LOCKED. Debounce counter `dbc` has width ceil(log2(DEBOUNCE_CYCLES+1)).
- IDLE:
  - `block_in`=1 → `dbc`=1.
  - If DEBOUNCE_CYCLES=1, go directly to LOCKED (detection actions below). Otherwise go to ARMING.
- ARMING:
  - `block_in`=0 → IDLE, `dbc`=0.
  - `block_in`=1 and `dbc`=DEBOUNCE_CYCLES-1 → LOCKED (detection actions).
  - Otherwise `dbc`+1.
- Detection actions, all registered at the same edge:
  - `deadlock_detected`←1, `deadlock_pulse`←1.
  - Snapshots ← current-cycle input vectors.
  - `stall_cycles`←0.
  - `event_count`←`event_count`+1, saturating at 2^CNT_WIDTH-1.
- LOCKED:
  - `stall_cycles`+1 each cycle `block_in`=1, saturating at all-ones; holds when `block_in`=0.
  - Deasserting `block_in` does not leave LOCKED (sticky).
  - Re-assertion does not create a new event or re-capture snapshots.
- `clear`=1 in any state:
  - Next state IDLE; `dbc`, `stall_cycles`, snapshots, `deadlock_detected` ← 0.
  - `event_count` preserved.
  - `clear` has priority over simultaneous detection: no pulse, no count, and that cycle's `block_in` sample is not counted toward the debounce.
- `event_count` is cleared only by `reset`.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `dbc`=0.
- Detection latency: with `block_in` first high in cycle 0 and held, `deadlock_detected`/`deadlock_pulse` assert after the rising edge ending cycle DEBOUNCE_CYCLES-1, i.e. visible in cycle DEBOUNCE_CYCLES.
- `deadlock_pulse` is exactly one cycle wide per detection.
- Snapshot equals input vectors sampled in cycle DEBOUNCE_CYCLES-1.
- `stall_cycles` first increments at the edge after detection if `block_in` is still high.
- `clear` takes effect at the next edge; outputs are 0 the following cycle.
- Asserting `reset` mid-ARMING or mid-LOCKED forces all outputs to 0 without waiting for a clock edge. After release, debounce restarts from 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- DEBOUNCE_CYCLES=16, `block_in` high 16 cycles → `deadlock_pulse` one cycle in cycle 16, `deadlock_detected`=1, `event_count`=1, snapshots equal cycle-15 vectors (e.g. idle=13'h0F0, block=9'h00F, axis=2'b01).
- `block_in` high 15 cycles, low 1, high 16 → no detection after the first burst; detection 16 cycles into the second burst; `event_count`=1.
- After detection, `block_in` high 40 more cycles then low 10 → `stall_cycles`=40 and holds; `deadlock_detected` stays 1; second rise adds no event.
- `clear` in the same cycle as the 16th high sample → no pulse, `event_count` unchanged, `deadlock_detected`=0. With `block_in` held high, detection 16 cycles after `clear`.
- CNT_WIDTH=4, 17 detect/clear cycles → `event_count` saturates at 15. Holding LOCKED 20 cycles → `stall_cycles`=15.
- Async `reset` pulse between edges during LOCKED → all outputs 0 before the next edge. DEBOUNCE_CYCLES=1: single high sample → detection the next cycle.
